// File: rtl/tq_mux32_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tq_mux32_scan_ctrl
// Description : Raster scan sequencer driving the 32:1 TQ coefficient mux
//               (column select, row index, row/block markers, done pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module tq_mux32_scan_ctrl #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [1:0]    size_i,
  input  logic          flush_i,
  input  logic          ready_i,
  output logic [AW-1:0] add_o,
  output logic [AW-1:0] row_o,
  output logic          valid_o,
  output logic          last_col_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_size;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_row;
  logic          r_valid;
  logic          r_last_col;
  logic          r_last;

  logic [AW-1:0] w_lim;
  logic          w_fire;
  logic          w_col_end;
  logic          w_row_end;
  logic [AW-1:0] w_col_nxt;
  logic [AW-1:0] w_row_nxt;

  // Highest legal index for the latched transform size: N-1 = (4 << size) - 1.
  assign w_lim     = AW'((32'd4 << r_size) - 32'd1);
  assign w_fire    = r_valid & ready_i;
  assign w_col_end = (r_col == w_lim);
  assign w_row_end = (r_row == w_lim);

  always_comb begin
    w_col_nxt = r_col + AW'(1);
    w_row_nxt = r_row;
    if (w_col_end) begin
      w_col_nxt = '0;
      w_row_nxt = r_row + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_size     <= 2'd0;
      r_col      <= '0;
      r_row      <= '0;
      r_valid    <= 1'b0;
      r_last_col <= 1'b0;
      r_last     <= 1'b0;
    end else if (flush_i) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_valid    <= 1'b0;
      r_last_col <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state    <= S_RUN;
            r_size     <= size_i;
            r_col      <= '0;
            r_row      <= '0;
            r_valid    <= 1'b1;
            // Smallest block is 4 wide, so the first sample is never a row end.
            r_last_col <= 1'b0;
            r_last     <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (w_col_end && w_row_end) begin
              r_state    <= S_DONE;
              r_col      <= '0;
              r_row      <= '0;
              r_valid    <= 1'b0;
              r_last_col <= 1'b0;
              r_last     <= 1'b0;
            end else begin
              r_col      <= w_col_nxt;
              r_row      <= w_row_nxt;
              r_last_col <= (w_col_nxt == w_lim);
              r_last     <= (w_col_nxt == w_lim) && (w_row_nxt == w_lim);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign add_o      = r_col;
  assign row_o      = r_row;
  assign valid_o    = r_valid;
  assign last_col_o = r_last_col;
  assign last_o     = r_last;
  assign busy_o     = (r_state == S_RUN) || (r_state == S_DONE);
  assign done_o     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tq_mux32_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tq_mux32_scan_ctrl
// Description : Randomized bench for the TQ scan sequencer against a queue of
//               expected (row, col) samples per block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tq_mux32_scan_ctrl;

  localparam int AW = 5;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    size_i  = 2'd0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [AW-1:0] add_o;
  logic [AW-1:0] row_o;
  logic          valid_o;
  logic          last_col_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tq_mux32_scan_ctrl #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .size_i     (size_i),
    .flush_i    (flush_i),
    .ready_i    (ready_i),
    .add_o      (add_o),
    .row_o      (row_o),
    .valid_o    (valid_o),
    .last_col_o (last_col_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_expect(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_lastcol"}, last_col_o, 0);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_add"}, add_o, 0);
    check({tag, "_row"}, row_o, 0);
    idle_expect(tag);
  endtask

  // rmode: 0 = ready always, 1 = ready pattern 1,0,0, 2 = random ready.
  // flush_at / rst_at: sample number at which to flush / reset (-1 = never).
  task automatic scan(input int sz, input int rmode, input int flush_at,
                      input int rst_at, input bit disturb);
    int n;
    int q_r[$];
    int q_c[$];
    int fires;
    bit ended;
    n = 4 << sz;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        q_r.push_back(r);
        q_c.push_back(c);
      end
    @(negedge clk);
    start_i = 1'b1;
    size_i  = sz[1:0];
    flush_i = 1'b0;
    ready_i = 1'b0;
    fires   = 0;
    ended   = 1'b0;
    for (int t = 0; t < 4 * n * n + 8; t++) begin
      @(negedge clk);
      start_i = disturb ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (disturb) size_i = 2'($urandom_range(0, 3));
      if (q_r.size() != 0) begin
        check("valid", valid_o, 1);
        check("busy", busy_o, 1);
        check("done_early", done_o, 0);
        check("add", add_o, q_c[0]);
        check("row", row_o, q_r[0]);
        check("last_col", last_col_o, q_c[0] == n - 1);
        check("last", last_o, (q_c[0] == n - 1) && (q_r[0] == n - 1));
        if (fires == flush_at) begin
          flush_i = 1'b1;
          ready_i = 1'b1;
          @(negedge clk);
          flush_i = 1'b0;
          start_i = 1'b0;
          idle_expect("flush");
          repeat (3) begin
            @(negedge clk);
            check("flush_nodone", done_o, 0);
            check("flush_novalid", valid_o, 0);
          end
          ended = 1'b1;
          break;
        end
        if (fires == rst_at) begin
          #2 rst_n = 1'b0;
          #1 all_zero("async_rst");
          @(negedge clk);
          rst_n   = 1'b1;
          start_i = 1'b0;
          repeat (3) begin
            @(negedge clk);
            all_zero("post_rst");
          end
          ended = 1'b1;
          break;
        end
        ready_i = (rmode == 0) ? 1'b1 :
                  (rmode == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
        if (ready_i) begin
          void'(q_r.pop_front());
          void'(q_c.pop_front());
          fires++;
        end
      end else begin
        check("end_valid", valid_o, 0);
        check("end_done", done_o, 1);
        check("end_busy", busy_o, 1);
        check("end_last", last_o, 0);
        check("fires", fires, n * n);
        if (rmode == 0) check("done_latency", t, n * n);
        start_i = 1'b1;
        ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        idle_expect("after_done");
        @(negedge clk);
        idle_expect("stay_idle");
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check("timeout", 0, 1);
    start_i = 1'b0;
    ready_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("idle");

    scan(0, 0, -1, -1, 1'b0);
    scan(3, 0, -1, -1, 1'b0);
    scan(1, 1, -1, -1, 1'b0);
    scan(2, 0, 5 * 16 + 7, -1, 1'b0);
    scan(0, 0, -1, -1, 1'b0);
    scan(2, 2, -1, -1, 1'b1);
    scan(1, 2, -1, -1, 1'b1);
    scan(3, 0, -1, 10 * 32, 1'b0);
    scan(0, 2, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++)
      scan(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, -1, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
